// File: rtl/fetch_stage_pkg.sv
// Shared types for the MIPS IF stage: next-PC select encodings, reset PC and fetch FSM states.
package fetch_stage_pkg;

    localparam int          NPC_OP_LENGTH    = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [NPC_OP_LENGTH-1:0] {
        NPC_PC4    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_REQ  = 2'b01,
        S_HOLD = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Single-outstanding instruction-memory handshake between the fetch stage and instruction memory.
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the redirect that ID resolves (PC+4, branch, jump, jr).
module npc_calc
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  npc_op_e           npcOp,
    input  logic [ADDR_W-1:0] pcF,
    input  logic [ADDR_W-1:0] pcPlus4D,
    input  logic [15:0]       immD,
    input  logic [25:0]       instrIndexD,
    input  logic [31:0]       rsDataD,
    output logic [ADDR_W-1:0] npc_o
);

    logic [ADDR_W-1:0] branch_off;
    logic [31:0]       rs_word;

    assign branch_off = {{(ADDR_W-18){immD[15]}}, immD, 2'b00};
    assign rs_word    = rsDataD & 32'hFFFF_FFFC;

    // Jump keeps the upper nibble of the ID instruction's PC+4, not of the fetch PC.
    always_comb begin
        npc_o = pcF + ADDR_W'(4);
        unique case (npcOp)
            NPC_PC4:    npc_o = pcF + ADDR_W'(4);
            NPC_BRANCH: npc_o = pcPlus4D + branch_off;
            NPC_JUMP:   npc_o = {pcPlus4D[ADDR_W-1:28], instrIndexD, 2'b00};
            NPC_JR:     npc_o = ADDR_W'(rs_word);
            default:    npc_o = pcF + ADDR_W'(4);
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches one instruction at a time and loads the IF/ID register,
// applying ID's redirect and squashing a response that belongs to the old path.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  npc_op_e            npcOp,
    input  logic [15:0]        immD,
    input  logic [25:0]        instrIndexD,
    input  logic [31:0]        rsDataD,
    input  logic               stallD,
    fetch_stage_if.master      imem,
    output logic [ADDR_W-1:0]  pcF,
    output logic [31:0]        instrD,
    output logic [ADDR_W-1:0]  pcPlus4D,
    output logic               validD
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] old_addr_q, old_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pcp4_q, pcp4_d;
    logic              valid_q, valid_d;
    logic              squash_q, squash_d;
    logic [31:0]       hold_q, hold_d;

    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              redirect;
    logic              req;

    npc_calc #(.ADDR_W(ADDR_W)) u_npc_calc (
        .npcOp       (npcOp),
        .pcF         (pc_q),
        .pcPlus4D    (pcp4_q),
        .immD        (immD),
        .instrIndexD (instrIndexD),
        .rsDataD     (rsDataD),
        .npc_o       (npc)
    );

    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign redirect = valid_q && !stallD && (npcOp != NPC_PC4);

    // While a squash is pending the address must stay on the old request until it completes.
    assign imem.imem_req  = req;
    assign imem.imem_addr = squash_q ? old_addr_q : pc_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        pc_d       = pc_q;
        old_addr_d = old_addr_q;
        instr_d    = instr_q;
        pcp4_d     = pcp4_q;
        valid_d    = valid_q;
        squash_d   = squash_q;
        hold_d     = hold_q;
        req        = 1'b0;

        unique case (state_q)
            S_BOOT: state_d = S_REQ;

            S_REQ: begin
                req = 1'b1;
                // ID hands its instruction on whenever it is not stalled; refill or bubble.
                if (!stallD) begin
                    valid_d = 1'b0;
                    instr_d = '0;
                end
                if (redirect) begin
                    pc_d       = npc;
                    squash_d   = !imem.imem_ready;
                    old_addr_d = squash_q ? old_addr_q : pc_q;
                end else if (imem.imem_ready) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                    end else if (stallD) begin
                        hold_d  = imem.imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        instr_d = imem.imem_rdata;
                        pcp4_d  = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end
            end

            S_HOLD: begin
                if (!stallD) begin
                    state_d = S_REQ;
                    hold_d  = '0;
                    if (redirect) begin
                        pc_d    = npc;
                        valid_d = 1'b0;
                        instr_d = '0;
                    end else begin
                        instr_d = hold_q;
                        pcp4_d  = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end
            end

            default: state_d = S_BOOT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            old_addr_q <= RESET_PC;
            instr_q    <= '0;
            pcp4_q     <= '0;
            valid_q    <= 1'b0;
            squash_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            old_addr_q <= old_addr_d;
            instr_q    <= instr_d;
            pcp4_q     <= pcp4_d;
            valid_q    <= valid_d;
            squash_q   <= squash_d;
            hold_q     <= hold_d;
        end
    end

    assign pcF      = pc_q;
    assign instrD   = instr_q;
    assign pcPlus4D = pcp4_q;
    assign validD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot fetch, branch/jump/jr redirects, squash, stall hold, wrap, reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    npc_op_e     npcOp;
    logic [15:0] immD;
    logic [25:0] instrIndexD;
    logic [31:0] rsDataD;
    logic        stallD;
    logic [31:0] pcF;
    logic [31:0] instrD;
    logic [31:0] pcPlus4D;
    logic        validD;

    int vectors     = 0;
    int miscompares = 0;

    fetch_stage_if #(.ADDR_W(32)) imem_if ();

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst         (rst),
        .npcOp       (npcOp),
        .immD        (immD),
        .instrIndexD (instrIndexD),
        .rsDataD     (rsDataD),
        .stallD      (stallD),
        .imem        (imem_if),
        .pcF         (pcF),
        .instrD      (instrD),
        .pcPlus4D    (pcPlus4D),
        .validD      (validD)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic rdy, input logic [31:0] data);
        imem_if.imem_ready = rdy;
        imem_if.imem_rdata = data;
        #1;
    endtask

    initial begin
        rst = 1'b0; npcOp = NPC_PC4; immD = '0; instrIndexD = '0; rsDataD = '0; stallD = 1'b0;
        imem_if.imem_ready = 1'b0; imem_if.imem_rdata = '0;
        cyc(); cyc();
        check("rst_pc",     pcF, 32'h0000_3000);
        check("rst_req",    32'(imem_if.imem_req), 32'd0);
        check("rst_instr",  instrD, 32'd0);
        check("rst_pcp4",   pcPlus4D, 32'd0);
        check("rst_valid",  32'(validD), 32'd0);

        rst = 1'b1; #1;
        check("boot_idle",  32'(imem_if.imem_req), 32'd0);
        cyc();
        check("req0",       32'(imem_if.imem_req), 32'd1);
        check("addr0",      imem_if.imem_addr, 32'h0000_3000);
        cyc(); mem(1'b1, 32'h2008_0001);
        check("addr0_hold", imem_if.imem_addr, 32'h0000_3000);
        cyc(); mem(1'b0, 32'h0);
        check("i0_instr",   instrD, 32'h2008_0001);
        check("i0_pcp4",    pcPlus4D, 32'h0000_3004);
        check("i0_valid",   32'(validD), 32'd1);
        check("addr1",      imem_if.imem_addr, 32'h0000_3004);
        cyc(); mem(1'b1, 32'h2009_0002);
        check("bubble",     32'(validD), 32'd0);
        cyc();
        check("i1_instr",   instrD, 32'h2009_0002);
        check("i1_pcp4",    pcPlus4D, 32'h0000_3008);

        // Branch back by two words; response in the same cycle is dropped.
        npcOp = NPC_BRANCH; immD = 16'hFFFE; mem(1'b1, 32'hDEAD_BEEF);
        cyc(); npcOp = NPC_PC4; mem(1'b1, 32'h2008_0001);
        check("br_addr",    imem_if.imem_addr, 32'h0000_3000);
        check("br_pc",      pcF, 32'h0000_3000);
        check("br_valid",   32'(validD), 32'd0);
        check("br_instr",   instrD, 32'd0);
        cyc(); mem(1'b1, 32'h2009_0002);
        check("br_refill",  instrD, 32'h2008_0001);
        check("br_valid1",  32'(validD), 32'd1);
        cyc(); mem(1'b1, 32'h0800_0C10);
        cyc();
        check("j_pcp4",     pcPlus4D, 32'h0000_300C);

        npcOp = NPC_JUMP; instrIndexD = 26'h0000C10; mem(1'b1, 32'h1111_1111);
        cyc(); npcOp = NPC_PC4; mem(1'b1, 32'h0800_0C03);
        check("j_addr",     imem_if.imem_addr, 32'h0000_3040);
        check("j_valid",    32'(validD), 32'd0);
        cyc();
        npcOp = NPC_JUMP; instrIndexD = 26'h0000C03; mem(1'b1, 32'h2222_2222);
        cyc(); npcOp = NPC_PC4; mem(1'b1, 32'h03E0_0008);
        check("j2_addr",    imem_if.imem_addr, 32'h0000_300C);
        cyc();
        check("jr_pcp4",    pcPlus4D, 32'h0000_3010);

        // jr while the request to 0x3010 is still waiting; its response must be squashed.
        npcOp = NPC_JR; rsDataD = 32'h0000_4003; mem(1'b0, 32'h0);
        check("jr_pend",    imem_if.imem_addr, 32'h0000_3010);
        cyc(); npcOp = NPC_PC4;
        check("jr_pc",      pcF, 32'h0000_4000);
        check("sq_addr0",   imem_if.imem_addr, 32'h0000_3010);
        check("sq_valid",   32'(validD), 32'd0);
        cyc(); mem(1'b1, 32'h9999_9999);
        check("sq_addr1",   imem_if.imem_addr, 32'h0000_3010);
        cyc(); mem(1'b1, 32'h2008_0001);
        check("sq_drop_v",  32'(validD), 32'd0);
        check("sq_drop_i",  instrD, 32'd0);
        check("jr_addr",    imem_if.imem_addr, 32'h0000_4000);
        cyc();
        check("pre_stall",  instrD, 32'h2008_0001);

        // Stall across a response for three cycles; a redirect inside the stall is ignored.
        stallD = 1'b1; mem(1'b1, 32'hAABB_CCDD);
        cyc(); mem(1'b0, 32'h0);
        check("st1_req",    32'(imem_if.imem_req), 32'd0);
        check("st1_instr",  instrD, 32'h2008_0001);
        check("st1_pc",     pcF, 32'h0000_4004);
        npcOp = NPC_JR; rsDataD = 32'h0000_5000;
        cyc(); npcOp = NPC_PC4;
        check("st2_req",    32'(imem_if.imem_req), 32'd0);
        check("st2_pc",     pcF, 32'h0000_4004);
        cyc(); stallD = 1'b0; #1;
        check("st3_instr",  instrD, 32'h2008_0001);
        check("st3_req",    32'(imem_if.imem_req), 32'd0);
        cyc();
        check("rel_instr",  instrD, 32'hAABB_CCDD);
        check("rel_pcp4",   pcPlus4D, 32'h0000_4008);
        check("rel_pc",     pcF, 32'h0000_4008);
        check("rel_addr",   imem_if.imem_addr, 32'h0000_4008);
        cyc();
        check("rel_once",   pcF, 32'h0000_4008);
        check("rel_bubble", 32'(validD), 32'd0);

        // Wrap-around past the top of the address space.
        mem(1'b1, 32'h2009_0002);
        cyc();
        npcOp = NPC_JR; rsDataD = 32'hFFFF_FFFF; mem(1'b1, 32'h3333_3333);
        cyc(); npcOp = NPC_PC4; mem(1'b1, 32'h0000_0000);
        check("wrap_addr",  imem_if.imem_addr, 32'hFFFF_FFFC);
        cyc(); mem(1'b0, 32'h0);
        check("wrap_pcp4",  pcPlus4D, 32'h0000_0000);
        check("wrap_pc",    pcF, 32'h0000_0000);
        check("wrap_valid", 32'(validD), 32'd1);
        cyc();
        npcOp = NPC_JUMP; instrIndexD = 26'h3FFFFFF; #1;
        cyc(); npcOp = NPC_PC4;
        check("nop_bubble", pcF, 32'h0000_0000);

        // Asynchronous reset in the middle of an active request.
        check("pre_rst_req", 32'(imem_if.imem_req), 32'd1);
        #2; rst = 1'b0; #1;
        check("ar_req",     32'(imem_if.imem_req), 32'd0);
        check("ar_pc",      pcF, 32'h0000_3000);
        check("ar_valid",   32'(validD), 32'd0);
        check("ar_pcp4",    pcPlus4D, 32'd0);
        cyc(); rst = 1'b1; #1;
        check("ar_boot",    32'(imem_if.imem_req), 32'd0);
        cyc();
        check("ar_req1",    32'(imem_if.imem_req), 32'd1);
        check("ar_addr1",   imem_if.imem_addr, 32'h0000_3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
